// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the fetch / PC sequencing logic.
//   pc_seq_state_t : sequencer states (RST_VEC, FETCH, WAIT, ISSUE)
//   INSTR_WIDTH    : instruction word width
//   PC_INC         : sequential PC increment in bytes
package cpu_pkg;

   typedef enum logic [1:0] {
      RST_VEC,
      FETCH,
      WAIT,
      ISSUE
   } pc_seq_state_t;

   localparam int INSTR_WIDTH = 32;
   localparam int PC_INC      = 4;

endpackage

// File: rtl/cpu_pc_next_sel.sv
// cpu_pc_next_sel: combinational next-PC priority mux.
// Ports:
//   trap_pend    in  pending trap (already merged with a same-cycle request)
//   br_taken     in  branch/jump taken
//   br_target    in  branch/jump target
//   instr_pc     in  PC of the retiring instruction
//   sel_pc       out next PC value
//   sel_trap     out a trap is taken on this retirement
//   sel_misalign out trap cause is a misaligned branch target
//   sel_epc      out PC to save as the exception PC
// Priority: pending trap, misaligned taken branch, taken branch, PC+4.
module cpu_pc_next_sel
   import cpu_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100
) (
   input  logic                  trap_pend,
   input  logic                  br_taken,
   input  logic [ADDR_WIDTH-1:0] br_target,
   input  logic [ADDR_WIDTH-1:0] instr_pc,
   output logic [ADDR_WIDTH-1:0] sel_pc,
   output logic                  sel_trap,
   output logic                  sel_misalign,
   output logic [ADDR_WIDTH-1:0] sel_epc
);

   logic [ADDR_WIDTH-1:0] pc_inc;

   // Sequential address wraps naturally at 2^ADDR_WIDTH.
   assign pc_inc = instr_pc + ADDR_WIDTH'(PC_INC);

   always_comb begin
      sel_pc       = pc_inc;
      sel_trap     = 1'b0;
      sel_misalign = 1'b0;
      sel_epc      = pc_inc;
      if (trap_pend) begin
         // Asynchronous-style trap: the current instruction retired, so
         // resume after it.
         sel_pc   = TRAP_VECTOR;
         sel_trap = 1'b1;
         sel_epc  = pc_inc;
      end else if (br_taken && (br_target[1:0] != 2'b00)) begin
         // Faulting branch: report the branch itself.
         sel_pc       = TRAP_VECTOR;
         sel_trap     = 1'b1;
         sel_misalign = 1'b1;
         sel_epc      = instr_pc;
      end else if (br_taken) begin
         sel_pc = br_target;
      end
   end

endmodule

// File: rtl/cpu_pc_sequencer.sv
// cpu_pc_sequencer: multicycle fetch / PC controller.
// Sequence: RST_VEC -> FETCH (request until granted) -> WAIT (until read
// data) -> ISSUE (until the core acknowledges) -> FETCH ...
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc_cur / pc_ld / pc_nxt  external PC register interface
//   imem_*                   instruction memory request/grant/response
//   instr_valid/instr/instr_pc/instr_ack  instruction hand-off to the core
//   br_taken, br_target      next-PC inputs, qualified by instr_ack
//   trap_req                 level trap request, any state
//   trap_taken/trap_epc/trap_misalign  trap reporting
// Optional: define CPU_PC_SEQ_PERF_CNT_EN to add perf_fetch_cnt (grants)
// and perf_wait_cnt (stall cycles).
module cpu_pc_sequencer
   import cpu_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_WIDTH-1:0]  pc_cur,
   output logic                   pc_ld,
   output logic [ADDR_WIDTH-1:0]  pc_nxt,
   output logic                   imem_req,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic                   imem_gnt,
   input  logic                   imem_rvalid,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic                   instr_valid,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0]  instr_pc,
   input  logic                   instr_ack,
   input  logic                   br_taken,
   input  logic [ADDR_WIDTH-1:0]  br_target,
   input  logic                   trap_req,
   output logic                   trap_taken,
   output logic [ADDR_WIDTH-1:0]  trap_epc,
   output logic                   trap_misalign
`ifdef CPU_PC_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]            perf_fetch_cnt,
   output logic [31:0]            perf_wait_cnt
`endif
);

   pc_seq_state_t          state_q, state_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_d;
   logic [ADDR_WIDTH-1:0]  trap_epc_q, trap_epc_d;
   logic                   trap_misalign_q, trap_misalign_d;
   logic                   trap_pend_q, trap_pend_d;

   logic [ADDR_WIDTH-1:0]  sel_pc, sel_epc;
   logic                   sel_trap, sel_misalign;

   // A request arriving together with the ack is honoured on that ack.
   cpu_pc_next_sel #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .TRAP_VECTOR (TRAP_VECTOR)
   ) u_next_sel (
      .trap_pend    (trap_pend_q | trap_req),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .instr_pc     (instr_pc_q),
      .sel_pc       (sel_pc),
      .sel_trap     (sel_trap),
      .sel_misalign (sel_misalign),
      .sel_epc      (sel_epc)
   );

   always_comb begin
      state_d         = state_q;
      instr_d         = instr_q;
      instr_pc_d      = instr_pc_q;
      trap_epc_d      = trap_epc_q;
      trap_misalign_d = trap_misalign_q;
      trap_pend_d     = trap_pend_q | trap_req;
      pc_ld           = 1'b0;
      pc_nxt          = RESET_VECTOR;
      imem_req        = 1'b0;
      imem_addr       = '0;
      instr_valid     = 1'b0;
      trap_taken      = 1'b0;

      case (state_q)
         RST_VEC: begin
            pc_ld   = 1'b1;
            state_d = FETCH;
         end
         FETCH: begin
            imem_req  = 1'b1;
            imem_addr = pc_cur;
            if (imem_gnt) state_d = WAIT;
         end
         WAIT: begin
            // Responses are only accepted here; stray rvalids elsewhere
            // (e.g. left over from before a reset) are dropped.
            if (imem_rvalid) begin
               instr_d    = imem_rdata;
               instr_pc_d = pc_cur;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            instr_valid = 1'b1;
            pc_nxt      = sel_pc;
            if (instr_ack) begin
               pc_ld   = 1'b1;
               state_d = FETCH;
               if (sel_trap) begin
                  trap_taken      = 1'b1;
                  trap_epc_d      = sel_epc;
                  trap_misalign_d = sel_misalign;
                  trap_pend_d     = 1'b0;
               end
            end
         end
         default: state_d = RST_VEC;
      endcase

      // While reset is held every output is quiet and pc_nxt shows the
      // reset vector, independent of the registered state.
      if (rst) begin
         pc_ld       = 1'b0;
         pc_nxt      = RESET_VECTOR;
         imem_req    = 1'b0;
         imem_addr   = '0;
         instr_valid = 1'b0;
         trap_taken  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= RST_VEC;
         instr_q         <= '0;
         instr_pc_q      <= '0;
         trap_epc_q      <= '0;
         trap_misalign_q <= 1'b0;
         trap_pend_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         instr_q         <= instr_d;
         instr_pc_q      <= instr_pc_d;
         trap_epc_q      <= trap_epc_d;
         trap_misalign_q <= trap_misalign_d;
         trap_pend_q     <= trap_pend_d;
      end
   end

   assign instr         = instr_q;
   assign instr_pc      = instr_pc_q;
   assign trap_epc      = trap_epc_q;
   assign trap_misalign = trap_misalign_q;

`ifdef CPU_PC_SEQ_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
   logic [31:0] perf_wait_cnt_q, perf_wait_cnt_d;

   always_comb begin
      perf_fetch_cnt_d = perf_fetch_cnt_q;
      perf_wait_cnt_d  = perf_wait_cnt_q;
      if (state_q == FETCH && imem_gnt)
         perf_fetch_cnt_d = perf_fetch_cnt_q + 32'd1;
      if (state_q == WAIT || (state_q == FETCH && !imem_gnt))
         perf_wait_cnt_d = perf_wait_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_cnt_q <= '0;
         perf_wait_cnt_q  <= '0;
      end else begin
         perf_fetch_cnt_q <= perf_fetch_cnt_d;
         perf_wait_cnt_q  <= perf_wait_cnt_d;
      end
   end

   assign perf_fetch_cnt = perf_fetch_cnt_q;
   assign perf_wait_cnt  = perf_wait_cnt_q;
`endif

endmodule
